// File: rtl/uart_tx.sv
// UART transmitter: idle-high line, start bit, 8 data bits LSB first,
// optional odd/even parity bit, then 1 or 2 stop bits.
//
// Parameters:
//   CLK_FREQ  - system clock frequency in Hz
//   BAUD      - line bit rate in bits/s (CLK_FREQ/BAUD must be >= 2)
//   PARITY    - 0 none, 1 odd, 2 even
//   STOP_BITS - 1 or 2
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-low reset
//   start   - transmit request, accepted only while idle
//   data_in - byte to send, captured on the accepting edge
//   tx      - serial line output (registered, idle high)
//   busy    - high while a frame is in progress (registered)
//
// A request is accepted on the edge where start=1 and the block is idle.
// From that edge the frame occupies exactly
//   (1 + 8 + P + STOP_BITS) * CLK_PER_BIT cycles, P = (PARITY != 0),
// after which busy drops and a new request can be taken on the next edge.
module uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 115_200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy
);

  localparam int CLK_PER_BIT = CLK_FREQ / BAUD;
  // Baud counter only ever needs to hold CLK_PER_BIT-1.
  localparam int CNT_W = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [2:0]       DATA_LAST = 3'd7;
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       bit_q,    bit_d;
  logic [7:0]       shift_q,  shift_d;
  logic             par_q,    par_d;
  logic             tx_q,     tx_d;
  logic             busy_q,   busy_d;

  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign tx      = tx_q;
  assign busy    = busy_q;

  // State and datapath registers. Reset forces the line high at once,
  // abandoning any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic. tx_d is the value the line takes
  // from the next edge on, so every bit change is computed one cycle
  // ahead and appears exactly on the edge that ends the previous bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;

    // Baud counter free-runs 0..CLK_PER_BIT-1 while a frame is active.
    if (state_q != ST_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          shift_d = data_in;
          // Odd mode: bit makes total ones odd, so it is the inverted XOR.
          par_d   = (PARITY == 1) ? ~(^data_in) : (^data_in);
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end

      ST_STOP: begin
        // bit_q counts stop bits here; the line is already high.
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = ST_IDLE;
            bit_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity/1 stop, odd/2 stop,
// even/2 stop) at 10 clocks per bit share one stimulus stream and are
// compared every cycle against a frame-level model, plus literal pins.
module tb_uart_tx;

  localparam int CPB = 10;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       start   = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] tx_w;
  logic [2:0] busy_w;

  // Model state: frame active, cycles since accept, captured byte.
  logic       m_busy [3];
  int         m_k    [3];
  logic [7:0] m_data [3];

  int checks = 0;
  int errors = 0;

  // Hand-written line sequence for 0xD6: start, 0,1,1,0,1,0,1,1, stop.
  logic [0:9] lit_seq = 10'b0011010111;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx #(
      .CLK_FREQ (100_000_000),
      .BAUD     (10_000_000),
      .PARITY   (g),
      .STOP_BITS((g == 0) ? 1 : 2)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .data_in(data_in),
      .tx     (tx_w[g]),
      .busy   (busy_w[g])
    );
  end

  // Instance i: parity mode i, stop bits 1 for i=0 else 2.
  function automatic int frame_len(input int i);
    return 9 + ((i != 0) ? 1 : 0) + ((i == 0) ? 1 : 2);
  endfunction

  // Line level of bit slot b of a frame carrying d on instance i.
  function automatic logic frame_bit(input int i, input logic [7:0] d, input int b);
    int ones;
    ones = $countones(d);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (i != 0 && b == 9) return (i == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_busy[i] <= 1'b0;
        m_k[i]    <= 0;
        m_data[i] <= 8'h00;
      end else if (m_busy[i]) begin
        if (m_k[i] + 1 >= frame_len(i) * CPB) m_busy[i] <= 1'b0;
        m_k[i] <= m_k[i] + 1;
      end else if (start) begin
        m_busy[i] <= 1'b1;
        m_k[i]    <= 0;
        m_data[i] <= data_in;
      end
    end
  end

  task automatic chk(input string name, input int tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %b expected %b", name, tag, $time, act, exp);
    end
  endtask

  // Advance one cycle and compare every instance against the model.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("tx", i, tx_w[i], m_busy[i] ? frame_bit(i, m_data[i], m_k[i] / CPB) : 1'b1);
      chk("busy", i, busy_w[i], m_busy[i]);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_w != 3'b000 && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (busy_w != 3'b000) begin
      errors++;
      $display("FAIL idle_timeout: busy got %b expected 000", busy_w);
    end
  endtask

  // Single frame with one literal line check at offset lit_off.
  task automatic send(input logic [7:0] d, input int lit_off, input int lit_inst,
                      input logic lit_exp, input string lit_name);
    start   = 1'b1;
    data_in = d;
    tick();
    start   = 1'b0;
    for (int off = 1; off <= lit_off; off++) tick();
    chk(lit_name, lit_inst, tx_w[lit_inst], lit_exp);
    wait_idle();
  endtask

  initial begin
    // Reset held, then released with start low.
    rst = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    rst = 1'b1;
    for (int n = 0; n < 20; n++) tick();

    // Basic 0xD6 frame, with a start pulse of 0x00 at cycle 30 that must be ignored.
    start   = 1'b1;
    data_in = 8'hD6;
    tick();
    start   = 1'b0;
    for (int off = 1; off <= 125; off++) begin
      if (off == 30) begin
        start   = 1'b1;
        data_in = 8'h00;
      end else if (off == 31) begin
        start   = 1'b0;
      end
      tick();
      if (off % 10 == 5 && off < 100) chk("lit_d6_tx", off, tx_w[0], lit_seq[off / 10]);
      if (off == 95) begin
        chk("lit_d6_odd_par", off, tx_w[1], 1'b0);
        chk("lit_d6_even_par", off, tx_w[2], 1'b1);
      end
      if (off == 99)  chk("lit_busy0_last", off, busy_w[0], 1'b1);
      if (off == 100) chk("lit_busy0_fall", off, busy_w[0], 1'b0);
      if (off == 119) chk("lit_busy1_last", off, busy_w[1], 1'b1);
      if (off == 120) chk("lit_busy1_fall", off, busy_w[1], 1'b0);
      if (off == 125) chk("lit_no_second_frame", off, busy_w[0], 1'b0);
    end
    wait_idle();

    // Back-to-back: start held high with 0x55.
    start   = 1'b1;
    data_in = 8'h55;
    tick();
    for (int off = 1; off <= 370; off++) begin
      tick();
      if (off == 95) begin
        chk("lit_55_odd_par", off, tx_w[1], 1'b1);
        chk("lit_55_even_par", off, tx_w[2], 1'b0);
      end
      if (off == 120) chk("lit_gap_idle", off, busy_w[1], 1'b0);
      if (off == 121) begin
        chk("lit_b2b_busy", off, busy_w[1], 1'b1);
        chk("lit_b2b_start", off, tx_w[1], 1'b0);
      end
    end

    // start still held; data_in churns while frames are in progress.
    for (int n = 0; n < 400; n++) begin
      data_in = 8'($urandom);
      tick();
    end
    start = 1'b0;
    wait_idle();

    // Reset during data bit 3 of 0xD6, off the clock edge.
    start   = 1'b1;
    data_in = 8'hD6;
    tick();
    start   = 1'b0;
    for (int off = 1; off <= 45; off++) tick();
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("async_rst_tx", i, tx_w[i], 1'b1);
      chk("async_rst_busy", i, busy_w[i], 1'b0);
    end
    for (int n = 0; n < 5; n++) tick();
    rst = 1'b1;
    for (int n = 0; n < 20; n++) tick();
    send(8'hD6, 45, 0, 1'b0, "lit_after_rst_bit3");

    // Edge data.
    send(8'h00, 95, 2, 1'b0, "lit_00_even_par");
    send(8'hFF, 95, 2, 1'b0, "lit_ff_even_par");
    send(8'hFF, 95, 1, 1'b1, "lit_ff_odd_par");

    // Random requests, some landing while busy.
    for (int n = 0; n < 1500; n++) begin
      start   = ($urandom_range(0, 7) == 0);
      data_in = 8'($urandom);
      tick();
    end
    start = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Parameterised UART transmitter. It serialises one byte per request onto an idle-high asynchronous serial line: start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits. It sits at the host-link output of the accelerator, driven by the response/readback logic through a start/busy handshake.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
BAUD, 115_200, line bit rate in bits/s.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, number of stop bits (1 or 2).
Derived constant CLK_PER_BIT = CLK_FREQ / BAUD (integer division, required ≥ 2). The counter width is sized to hold CLK_PER_BIT-1.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  transmit request; sampled on the rising clk edge.
data_in  input  8  byte to send; sampled only in the cycle the request is accepted.
tx  output  1  serial line; idle high.
busy  output  1  high while a frame is in progress.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-low.
- Reset (rst=0, asynchronous): tx=1, busy=0, state=IDLE, and the bit counter, baud counter and shift register cleared. This applies immediately, including mid-frame. Any partial frame is abandoned and the line returns high at once.
- All outputs are registered, so there are no combinational paths from inputs to tx or busy.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, busy=0. On a rising edge with start=1:
  - data_in is latched into the shift register.
  - Odd/even parity of data_in is computed.
  - The baud counter is cleared.
  - The state goes to START, and from that edge tx=0 and busy=1.
- START: tx=0 for exactly CLK_PER_BIT cycles, then go to DATA.
- DATA: transmit bits 0..7, LSB first, each held for CLK_PER_BIT cycles. After bit 7, go to PARITY if PARITY≠0, otherwise go to STOP.
- PARITY:
  - Odd mode sends the bit that makes the total count of ones (data + parity) odd.
  - Even mode sends the bit that makes that count even.
  - The bit is held for CLK_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS×CLK_PER_BIT cycles, then return to IDLE with busy=0.
- Frame length from the accepting edge to busy falling = (1+8+P+STOP_BITS)×CLK_PER_BIT cycles, where P=1 if parity is enabled, else 0.
- start while busy=1 is ignored. The request is not queued, and changes to data_in while busy have no effect on the frame.
- Back-to-back: start=1 in the first cycle busy reads 0 is accepted. The minimum idle gap between frames is therefore one clock.
- start held high continuously produces consecutive frames separated by one idle cycle.
- The baud counter counts 0..CLK_PER_BIT-1. The bit transition occurs when the counter reaches CLK_PER_BIT-1, and the counter then wraps to 0.

Test Plan:
- Reset: hold rst=0 for 10 cycles -> tx=1 and busy=0 throughout. Release with start=0 -> outputs stay idle indefinitely.
- Basic frame: CLK_FREQ=100e6, BAUD=10e6 (10 clk/bit), PARITY=0, STOP_BITS=1, data_in=0xD6, start pulsed for one cycle after reset -> tx sequence is start 0, then data 0,1,1,0,1,0,1,1, then stop 1, each bit lasting exactly 10 cycles. busy is high for exactly 100 cycles, then 0.
- Busy lockout: start pulsed again with data_in=0x00 at cycle 30 of a 0xD6 frame -> the frame is unchanged, and no second frame follows.
- Back-to-back and parity: PARITY=1 (odd), STOP_BITS=2, start held high, data_in=0x55 -> each frame is 0, 1,0,1,0,1,0,1,0, parity 1, 1,1 (120 cycles). Frames repeat with a 1-cycle idle gap. With PARITY=2 (even) the parity bit is 0.
- Reset mid-frame: rst=0 during bit 3 of 0xD6 -> tx=1 and busy=0 immediately, without waiting for a clock edge. After release the line stays idle, and the next start produces a complete, correct frame.
- Edge data: 0x00 and 0xFF with PARITY=2 -> 8 zeros with parity 0, and 8 ones with parity 0. Bit widths are exactly CLK_PER_BIT in all states.
